// File: rtl/agc_scaler_pkg.sv
// Shared types and defaults for the AGC binary scaler stage.
// Stage k of the scaler maps onto counter bit k-2.
package agc_scaler_pkg;

    typedef enum logic [1:0] {
        AWAKE   = 2'd0,
        SBY_ARM = 2'd1,
        STANDBY = 2'd2,
        WAKE    = 2'd3
    } sby_state_e;

    localparam int DEF_STAGES     = 33;
    localparam int DEF_SBY_STAGE  = 17;
    localparam int DEF_WDOG_LIMIT = 4096;

    // Scaler stage number (FS02 .. FS<STAGES>) to counter / output bit index.
    function automatic int stage_bit(input int stage);
        return stage - 2;
    endfunction

endpackage

// File: rtl/agc_scaler_watchdog.sv
// Scaler failure watchdog: flags SCAFAL once WDOG_LIMIT clocks pass with no
// FS01 advance, and drops it again on the next advance.
module agc_scaler_watchdog
    import agc_scaler_pkg::*;
#(
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic CLOCK,
    input  logic SIM_RST,
    input  logic adv,
    output logic SCAFAL
);

    localparam int WW = $clog2(WDOG_LIMIT + 1);
    localparam logic [WW-1:0] LIMIT = WW'(WDOG_LIMIT);

    logic [WW-1:0] wdog;

    // An advance in the same cycle the limit would be reached clears instead.
    always_ff @(posedge CLOCK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            wdog   <= '0;
            SCAFAL <= 1'b0;
        end else if (adv) begin
            wdog   <= '0;
            SCAFAL <= 1'b0;
        end else if (wdog != LIMIT) begin
            wdog <= wdog + WW'(1);
            if (wdog == LIMIT - WW'(1)) begin
                SCAFAL <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/agc_scaler.sv
// Binary scaler fed by FS01: ripple count with per-stage rising-edge pulses,
// standby sequencer issuing GOJ1 on wake, and the failure watchdog.
module agc_scaler
    import agc_scaler_pkg::*;
#(
    parameter int STAGES     = DEF_STAGES,
    parameter int SBY_STAGE  = DEF_SBY_STAGE,
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic              CLOCK,
    input  logic              SIM_RST,
    input  logic              FS01,
    input  logic              SBY,
    output logic [STAGES-2:0] FS,
    output logic [STAGES-2:0] F,
    output logic              WRAP,
    output logic              STBY,
    output logic              GOJ1,
    output logic              SCAFAL
);

    localparam int W       = STAGES - 1;
    localparam int SBY_BIT = stage_bit(SBY_STAGE);

    logic         fs01_q;
    logic         primed;
    logic         adv;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_inc;

    // primed masks the first clock after reset so a level already high is not an edge.
    assign adv     = FS01 & ~fs01_q & primed;
    assign cnt_inc = cnt + W'(1);
    assign FS      = cnt;

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge CLOCK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            fs01_q <= 1'b0;
            primed <= 1'b0;
            cnt    <= '0;
            F      <= '0;
            WRAP   <= 1'b0;
        end else begin
            fs01_q <= FS01;
            primed <= 1'b1;
            if (adv) begin
                cnt <= cnt_inc;
            end
            // Bits that go 0->1 on the increment; a wrap has none.
            F    <= adv ? (cnt_inc & ~cnt) : '0;
            WRAP <= adv & (&cnt);
        end
    end

    sby_state_e state;
    sby_state_e state_nxt;
    logic       f_gate;

    assign f_gate = F[SBY_BIT];

    always_ff @(posedge CLOCK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state <= AWAKE;
            STBY  <= 1'b0;
            GOJ1  <= 1'b0;
        end else begin
            state <= state_nxt;
            STBY  <= (state_nxt == STANDBY) || (state_nxt == WAKE);
            GOJ1  <= (state == WAKE) && (state_nxt == AWAKE);
        end
    end

    // NOTE: state_nxt takes its default before the case so no path infers a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            AWAKE:   if (SBY) state_nxt = SBY_ARM;
            SBY_ARM: begin
                if (!SBY)        state_nxt = AWAKE;
                else if (f_gate) state_nxt = STANDBY;
            end
            STANDBY: if (!SBY) state_nxt = WAKE;
            WAKE:    if (f_gate) state_nxt = AWAKE;
        endcase
    end

    agc_scaler_watchdog #(
        .WDOG_LIMIT(WDOG_LIMIT)
    ) u_watchdog (
        .CLOCK (CLOCK),
        .SIM_RST(SIM_RST),
        .adv   (adv),
        .SCAFAL(SCAFAL)
    );

endmodule

// File: tb/tb_agc_scaler.sv
// Self-checking bench for agc_scaler: directed steps plus random FS01/SBY
// traffic, all compared against a cycle-level behavioural model.
module tb_agc_scaler;

    localparam int STAGES     = 12;
    localparam int SBY_STAGE  = 6;
    localparam int WDOG_LIMIT = 4096;
    localparam int W          = STAGES - 1;
    localparam int SF         = SBY_STAGE - 2;

    localparam int M_AWAKE   = 0;
    localparam int M_ARM     = 1;
    localparam int M_STANDBY = 2;
    localparam int M_WAKE    = 3;

    logic         CLOCK = 1'b0;
    logic         SIM_RST;
    logic         FS01;
    logic         SBY;
    logic [W-1:0] FS;
    logic [W-1:0] F;
    logic         WRAP;
    logic         STBY;
    logic         GOJ1;
    logic         SCAFAL;

    int tests = 0;
    int fails = 0;

    // Behavioural model state and expected outputs.
    logic         m_fs01_q;
    bit           m_primed;
    int           m_mode;
    int           m_idle;
    logic [W-1:0] e_fs;
    logic [W-1:0] e_f;
    logic         e_wrap;
    logic         e_stby;
    logic         e_goj1;
    logic         e_scafal;

    agc_scaler #(
        .STAGES    (STAGES),
        .SBY_STAGE (SBY_STAGE),
        .WDOG_LIMIT(WDOG_LIMIT)
    ) dut (
        .CLOCK  (CLOCK),
        .SIM_RST(SIM_RST),
        .FS01   (FS01),
        .SBY    (SBY),
        .FS     (FS),
        .F      (F),
        .WRAP   (WRAP),
        .STBY   (STBY),
        .GOJ1   (GOJ1),
        .SCAFAL (SCAFAL)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fs01_q = 1'b0;
        m_primed = 1'b0;
        m_mode   = M_AWAKE;
        m_idle   = 0;
        e_fs     = '0;
        e_f      = '0;
        e_wrap   = 1'b0;
        e_stby   = 1'b0;
        e_goj1   = 1'b0;
        e_scafal = 1'b0;
    endtask

    // One clock of the specified behaviour, given the inputs held across the edge.
    task automatic model_step(input logic fs01, input logic sby);
        bit           adv;
        bit           f_gate;
        int           prev_mode;
        logic [W-1:0] old_fs;
        adv      = m_primed && fs01 && !m_fs01_q;
        m_fs01_q = fs01;
        m_primed = 1'b1;
        f_gate   = e_f[SF];
        old_fs   = e_fs;
        if (adv) e_fs = e_fs + W'(1);
        e_f    = e_fs & ~old_fs;
        e_wrap = adv && (e_fs == '0);
        prev_mode = m_mode;
        case (m_mode)
            M_AWAKE:   if (sby) m_mode = M_ARM;
            M_ARM:     if (!sby) m_mode = M_AWAKE; else if (f_gate) m_mode = M_STANDBY;
            M_STANDBY: if (!sby) m_mode = M_WAKE;
            default:   if (f_gate) m_mode = M_AWAKE;
        endcase
        e_stby   = (m_mode == M_STANDBY) || (m_mode == M_WAKE);
        e_goj1   = (prev_mode == M_WAKE) && (m_mode == M_AWAKE);
        m_idle   = adv ? 0 : ((m_idle < WDOG_LIMIT) ? m_idle + 1 : m_idle);
        e_scafal = (m_idle >= WDOG_LIMIT);
    endtask

    task automatic check_model();
        check("model_FS", 64'(FS), 64'(e_fs));
        check("model_F", 64'(F), 64'(e_f));
        check("model_WRAP", 64'(WRAP), 64'(e_wrap));
        check("model_STBY", 64'(STBY), 64'(e_stby));
        check("model_GOJ1", 64'(GOJ1), 64'(e_goj1));
        check("model_SCAFAL", 64'(SCAFAL), 64'(e_scafal));
    endtask

    // Advance one clock, update the model, check everything at the falling edge.
    task automatic cyc();
        @(posedge CLOCK);
        if (!SIM_RST) model_reset();
        else model_step(FS01, SBY);
        @(negedge CLOCK);
        check_model();
    endtask

    task automatic edge_pulse();
        FS01 = 1'b1;
        cyc();
        FS01 = 1'b0;
        cyc();
    endtask

    task automatic async_reset();
        SIM_RST = 1'b0;
        #1;
        model_reset();
        check_model();
    endtask

    initial begin
        logic [W-1:0] exp_f_tbl [4];
        logic [W-1:0] ones;
        logic [W-1:0] nx;
        exp_f_tbl = '{W'(1), W'(2), W'(1), W'(4)};
        ones      = '1;

        // Reset state.
        SIM_RST = 1'b0;
        FS01    = 1'b0;
        SBY     = 1'b0;
        model_reset();
        #1;
        check("rst_FS", 64'(FS), 64'(0));
        check("rst_F", 64'(F), 64'(0));
        check("rst_STBY", 64'(STBY), 64'(0));
        check("rst_SCAFAL", 64'(SCAFAL), 64'(0));
        cyc();
        cyc();
        SIM_RST = 1'b1;
        cyc();

        // Four FS01 edges: F0, F1, F0, F2 pulses, then FS = 4.
        for (int k = 0; k < 4; k++) begin
            FS01 = 1'b1;
            cyc();
            check($sformatf("edge%0d_F", k + 1), 64'(F), 64'(exp_f_tbl[k]));
            FS01 = 1'b0;
            cyc();
            check($sformatf("edge%0d_F_clear", k + 1), 64'(F), 64'(0));
        end
        check("four_edges_FS", 64'(FS), 64'(4));

        // FS01 high across reset release is not an edge.
        async_reset();
        FS01 = 1'b1;
        cyc();
        SIM_RST = 1'b1;
        repeat (3) cyc();
        check("hold_high_FS", 64'(FS), 64'(0));
        FS01 = 1'b0;
        cyc();
        FS01 = 1'b1;
        cyc();
        check("hold_high_then_edge_FS", 64'(FS), 64'(1));
        FS01 = 1'b0;
        cyc();

        // Count up to all-ones, then wrap.
        async_reset();
        cyc();
        SIM_RST = 1'b1;
        cyc();
        repeat ((1 << W) - 1) edge_pulse();
        check("pre_wrap_FS", 64'(FS), 64'(ones));
        FS01 = 1'b1;
        cyc();
        check("wrap_FS", 64'(FS), 64'(0));
        check("wrap_WRAP", 64'(WRAP), 64'(1));
        check("wrap_F", 64'(F), 64'(0));
        FS01 = 1'b0;
        cyc();
        check("wrap_WRAP_clear", 64'(WRAP), 64'(0));

        // Standby entry on the gating stage pulse.
        SBY = 1'b1;
        cyc();
        for (int i = 0; i < 64 && !STBY; i++) edge_pulse();
        check("sby_enter_STBY", 64'(STBY), 64'(1));
        check("sby_enter_FS", 64'(FS), 64'(1 << SF));

        // Wake: STBY holds through WAKE, GOJ1 one cycle on return to AWAKE.
        SBY = 1'b0;
        cyc();
        check("wake_STBY_hold", 64'(STBY), 64'(1));
        for (int i = 0; i < 64 && !GOJ1; i++) begin
            if (i == 3) SBY = 1'b1;
            edge_pulse();
        end
        check("wake_GOJ1", 64'(GOJ1), 64'(1));
        check("wake_STBY", 64'(STBY), 64'(0));
        cyc();
        check("wake_GOJ1_one_cycle", 64'(GOJ1), 64'(0));

        // SBY dropped in the cycle the gating pulse is visible: stay awake.
        for (int i = 0; i < 64; i++) begin
            nx = e_fs + W'(1);
            if (nx[SF] && !e_fs[SF]) break;
            edge_pulse();
        end
        FS01 = 1'b1;
        cyc();
        check("race_F_gate", 64'(F[SF]), 64'(1));
        SBY  = 1'b0;
        FS01 = 1'b0;
        cyc();
        check("race_STBY", 64'(STBY), 64'(0));
        repeat (4) edge_pulse();
        check("race_STBY_later", 64'(STBY), 64'(0));

        // Random FS01 / SBY traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            FS01 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) SBY = ~SBY;
            cyc();
        end
        SBY  = 1'b0;
        FS01 = 1'b0;
        cyc();

        // Watchdog: SCAFAL exactly at the limit, cleared by the next edge.
        edge_pulse();
        repeat (WDOG_LIMIT - 2) cyc();
        check("wdog_before_limit", 64'(SCAFAL), 64'(0));
        cyc();
        check("wdog_at_limit", 64'(SCAFAL), 64'(1));
        repeat (20) cyc();
        check("wdog_hold", 64'(SCAFAL), 64'(1));
        FS01 = 1'b1;
        cyc();
        check("wdog_clear", 64'(SCAFAL), 64'(0));

        // Edge arriving on the limit cycle wins.
        FS01 = 1'b0;
        cyc();
        repeat (WDOG_LIMIT - 2) cyc();
        FS01 = 1'b1;
        cyc();
        check("wdog_edge_on_limit", 64'(SCAFAL), 64'(0));
        FS01 = 1'b0;
        cyc();

        // Asynchronous reset while in WAKE: everything clears, no GOJ1.
        SBY = 1'b1;
        cyc();
        for (int i = 0; i < 64 && !STBY; i++) edge_pulse();
        SBY = 1'b0;
        cyc();
        check("pre_arst_STBY", 64'(STBY), 64'(1));
        edge_pulse();
        async_reset();
        check("arst_FS", 64'(FS), 64'(0));
        check("arst_STBY", 64'(STBY), 64'(0));
        check("arst_GOJ1", 64'(GOJ1), 64'(0));
        cyc();
        SIM_RST = 1'b1;
        repeat (5) cyc();
        check("post_arst_GOJ1", 64'(GOJ1), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
